// File: rtl/weight_ram_loader_pkg.sv
// weight_ram_loader_pkg: shared loader/read-driver types, constants and weight address map
package weight_ram_loader_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int UNITS = 4;
  localparam int INPUTS = 4;
  localparam int MAX_LAYERS = 4;
  typedef enum logic [2:0] {IDLE, SYNC, COUNT, DATA, CHECK, DONE, ERR} state_t;
  // Offset of a weight relative to BASE_ADDR; the read driver uses the same map
  function automatic int weight_offset(int layer, int unit, int inp, int units = UNITS, int inputs = INPUTS);
    return (layer * units + unit) * inputs + inp;
  endfunction
endpackage

// File: rtl/weight_ram_loader_if.sv
// weight_ram_loader_if: host byte stream, RAM write port and status of the weight loader
interface weight_ram_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic load_start;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic ram_we;
  logic [DATA_W-1:0] ram_din;
  logic busy;
  logic load_done;
  logic load_err;
  logic [ADDR_W-1:0] words_written;
  modport master (
    output load_start, in_data, in_valid,
    input in_ready, ram_addr, ram_we, ram_din, busy, load_done, load_err, words_written
  );
  modport slave (
    input load_start, in_data, in_valid,
    output in_ready, ram_addr, ram_we, ram_din, busy, load_done, load_err, words_written
  );
endinterface

// File: rtl/weight_ram_loader_addr_counter.sv
// weight_ram_loader_addr_counter: nested input/unit/layer counters, last-weight flag and address
module weight_ram_loader_addr_counter #(
  parameter int ADDR_W = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int UNITS = 4,
  parameter int INPUTS = 4
) (
  input logic clk,
  input logic reset,
  input logic clear,
  input logic step,
  input logic [7:0] n_layers,
  output logic [ADDR_W-1:0] addr,
  output logic last
);
  import weight_ram_loader_pkg::*;
  logic [7:0] layer, unit, inp;
  logic inp_wrap, unit_wrap;
  assign inp_wrap = inp == 8'(INPUTS - 1);
  assign unit_wrap = unit == 8'(UNITS - 1);
  assign last = inp_wrap && unit_wrap && layer == n_layers - 8'd1;
  assign addr = BASE_ADDR + ADDR_W'(weight_offset(int'(layer), int'(unit), int'(inp), UNITS, INPUTS));
  always_ff @(posedge clk or posedge reset)
    if (reset || clear) begin
      layer <= '0;
      unit <= '0;
      inp <= '0;
    end else if (step) begin
      inp <= inp_wrap ? 8'd0 : inp + 8'd1;
      unit <= inp_wrap ? (unit_wrap ? 8'd0 : unit + 8'd1) : unit;
      layer <= inp_wrap && unit_wrap ? layer + 8'd1 : layer;
    end
endmodule

// File: rtl/weight_ram_loader.sv
// weight_ram_loader: fills the weight RAM from a framed, checksummed host byte stream
module weight_ram_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [7:0] SYNC_BYTE = weight_ram_loader_pkg::SYNC_BYTE,
  parameter int UNITS = weight_ram_loader_pkg::UNITS,
  parameter int INPUTS = weight_ram_loader_pkg::INPUTS,
  parameter int MAX_LAYERS = weight_ram_loader_pkg::MAX_LAYERS
) (
  input logic clk,
  input logic reset,
  weight_ram_loader_if.slave bus
);
  import weight_ram_loader_pkg::*;
  state_t state;
  logic [7:0] n_layers, csum;
  logic [ADDR_W-1:0] addr;
  logic last, acc, step, clear, n_ok;
  assign bus.in_ready = state inside {SYNC, COUNT, DATA, CHECK};
  assign bus.busy = state != IDLE;
  assign bus.load_done = state == DONE;
  assign acc = bus.in_valid && bus.in_ready;
  assign step = acc && state == DATA;
  assign clear = bus.load_start && state == IDLE;
  assign n_ok = bus.in_data != 8'd0 && bus.in_data <= 8'(MAX_LAYERS);
  weight_ram_loader_addr_counter #(
    .ADDR_W(ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .UNITS(UNITS),
    .INPUTS(INPUTS)
  ) u_addr (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .step(step),
    .n_layers(n_layers),
    .addr(addr),
    .last(last)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      n_layers <= '0;
      csum <= '0;
      bus.ram_addr <= '0;
      bus.ram_we <= 1'b0;
      bus.ram_din <= '0;
      bus.load_err <= 1'b0;
      bus.words_written <= '0;
    end else begin
      bus.ram_we <= step;
      case (state)
        IDLE:
          if (bus.load_start) begin
            state <= SYNC;
            csum <= '0;
            bus.load_err <= 1'b0;
            bus.words_written <= '0;
          end
        SYNC: if (acc && bus.in_data == SYNC_BYTE) state <= COUNT;
        COUNT:
          if (acc) begin
            n_layers <= bus.in_data;
            state <= n_ok ? DATA : ERR;
            bus.load_err <= !n_ok;
          end
        DATA:
          if (acc) begin
            bus.ram_addr <= addr;
            bus.ram_din <= {{(DATA_W - 8){1'b0}}, bus.in_data};
            csum <= csum + bus.in_data;
            bus.words_written <= bus.words_written + ADDR_W'(1);
            state <= last ? CHECK : DATA;
          end
        CHECK:
          if (acc) begin
            state <= bus.in_data == csum ? DONE : ERR;
            bus.load_err <= bus.in_data != csum;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_weight_ram_loader.sv
// tb_weight_ram_loader: directed and randomized frames checked against a frame-level model
module tb_weight_ram_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  weight_ram_loader_if #(.ADDR_W(10), .DATA_W(32)) bus();
  weight_ram_loader dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cycles = 0;
  logic [31:0] ram_img [0:1023];
  logic [31:0] snap [0:63];
  logic [9:0] w_addr [$];
  logic [31:0] w_din [$];
  int w_cyc [$];
  logic [7:0] dq [$];

  // Write monitor: the bench's own view of the RAM
  always @(negedge clk) begin
    cyc++;
    if (bus.ram_we) begin
      w_addr.push_back(bus.ram_addr);
      w_din.push_back(bus.ram_din);
      w_cyc.push_back(cyc);
      ram_img[bus.ram_addr] = bus.ram_din;
    end
    if (bus.load_done) done_cycles++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    int k = 0;
    while (gaps && $urandom_range(0, 2) == 0) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_data = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) chk("ready_timeout", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] n, input logic [7:0] cs, input bit gaps);
    send(8'hA5, gaps);
    send(n, gaps);
    foreach (dq[k]) send(dq[k], gaps);
    send(cs, gaps);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", 64'(bus.busy), 64'd0);
  endtask

  function automatic logic [7:0] sum_dq();
    logic [7:0] s = 8'd0;
    foreach (dq[k]) s += dq[k];
    return s;
  endfunction

  // Layer/unit/input nesting makes the k-th data byte land at BASE_ADDR + k
  task automatic check_writes(input string tag, input int mark);
    chk({tag, "_count"}, 64'(w_addr.size() - mark), 64'(dq.size()));
    for (int k = 0; k < dq.size() && mark + k < w_addr.size(); k++) begin
      chk({tag, "_addr"}, 64'(w_addr[mark + k]), 64'(k));
      chk({tag, "_din"}, 64'(w_din[mark + k]), {56'd0, dq[k]});
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_we"}, 64'(bus.ram_we), 64'd0);
    chk({tag, "_done"}, 64'(bus.load_done), 64'd0);
    chk({tag, "_err"}, 64'(bus.load_err), 64'd0);
    chk({tag, "_words"}, 64'(bus.words_written), 64'd0);
    chk({tag, "_addr"}, 64'(bus.ram_addr), 64'd0);
    chk({tag, "_din"}, 64'(bus.ram_din), 64'd0);
  endtask

  initial begin
    int mark, d0, n;
    bus.load_start = 1'b0;
    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;
    #12;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // one layer, bytes 00..0F, back-to-back
    mark = w_addr.size();
    d0 = done_cycles;
    dq.delete();
    for (int k = 0; k < 16; k++) dq.push_back(8'(k));
    pulse_start();
    frame(8'h01, 8'h78, 1'b0);
    wait_idle();
    check_writes("t1", mark);
    chk("t1_done", 64'(done_cycles - d0), 64'd1);
    chk("t1_err", 64'(bus.load_err), 64'd0);
    chk("t1_words", 64'(bus.words_written), 64'd16);
    chk("t1_nobubble", 64'(w_cyc[mark + 15] - w_cyc[mark]), 64'd15);

    // noise before sync, two layers of 01
    mark = w_addr.size();
    d0 = done_cycles;
    dq.delete();
    for (int k = 0; k < 32; k++) dq.push_back(8'h01);
    pulse_start();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    frame(8'h02, 8'h20, 1'b0);
    wait_idle();
    check_writes("t2", mark);
    chk("t2_done", 64'(done_cycles - d0), 64'd1);
    chk("t2_words", 64'(bus.words_written), 64'd32);

    // layer count out of range: 5 and 0
    for (int t = 0; t < 2; t++) begin
      mark = w_addr.size();
      d0 = done_cycles;
      pulse_start();
      send(8'hA5, 1'b0);
      send(t == 0 ? 8'h05 : 8'h00, 1'b0);
      wait_idle();
      chk("t3_nowrite", 64'(w_addr.size() - mark), 64'd0);
      chk("t3_err", 64'(bus.load_err), 64'd1);
      chk("t3_ready", 64'(bus.in_ready), 64'd0);
      chk("t3_nodone", 64'(done_cycles - d0), 64'd0);
    end
    pulse_start();
    chk("t3_errclr", 64'(bus.load_err), 64'd0);
    chk("t3_armed", 64'(bus.busy), 64'd1);

    // bad checksum on the already armed loader
    mark = w_addr.size();
    d0 = done_cycles;
    dq.delete();
    for (int k = 0; k < 16; k++) dq.push_back(8'(k));
    frame(8'h01, 8'h00, 1'b0);
    wait_idle();
    check_writes("t4", mark);
    chk("t4_err", 64'(bus.load_err), 64'd1);
    chk("t4_nodone", 64'(done_cycles - d0), 64'd0);

    // random four-layer frame, back-to-back then with random in_valid gaps
    dq.delete();
    for (int k = 0; k < 64; k++) dq.push_back(8'($urandom_range(0, 255)));
    for (int g = 0; g < 2; g++) begin
      mark = w_addr.size();
      d0 = done_cycles;
      pulse_start();
      frame(8'h04, sum_dq(), g == 1);
      wait_idle();
      check_writes(g == 0 ? "t5b" : "t5g", mark);
      chk("t5_done", 64'(done_cycles - d0), 64'd1);
      chk("t5_err", 64'(bus.load_err), 64'd0);
      chk("t5_words", 64'(bus.words_written), 64'd64);
      if (g == 0) for (int k = 0; k < 64; k++) snap[k] = ram_img[k];
    end
    for (int k = 0; k < 64; k++) chk("t5_image", 64'(ram_img[k]), 64'(snap[k]));

    // random layer count with gaps
    n = $urandom_range(1, 4);
    dq.delete();
    for (int k = 0; k < n * 16; k++) dq.push_back(8'($urandom_range(0, 255)));
    mark = w_addr.size();
    d0 = done_cycles;
    pulse_start();
    frame(8'(n), sum_dq(), 1'b1);
    wait_idle();
    check_writes("t5r", mark);
    chk("t5r_done", 64'(done_cycles - d0), 64'd1);
    chk("t5r_words", 64'(bus.words_written), 64'(n * 16));

    // reset after 7 data bytes, then a fresh frame
    dq.delete();
    for (int k = 0; k < 7; k++) dq.push_back(8'($urandom_range(0, 255)));
    pulse_start();
    send(8'hA5, 1'b0);
    send(8'h02, 1'b0);
    foreach (dq[k]) send(dq[k], 1'b0);
    chk("t6_midframe", 64'(bus.busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_zero("t6_reset");
    chk("t6_partial", 64'(ram_img[6]), {56'd0, dq[6]});
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    dq.delete();
    for (int k = 0; k < 16; k++) dq.push_back(8'($urandom_range(0, 255)));
    mark = w_addr.size();
    d0 = done_cycles;
    pulse_start();
    frame(8'h01, sum_dq(), 1'b0);
    wait_idle();
    check_writes("t6", mark);
    chk("t6_done", 64'(done_cycles - d0), 64'd1);
    chk("t6_err", 64'(bus.load_err), 64'd0);
    chk("t6_words", 64'(bus.words_written), 64'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/weight_ram_loader.md
Name: weight_ram_loader

Overview:
- Write-side counterpart of the weight RAM read driver: fills the 32-bit weight RAM (10-bit address) before the network runs.
- Accepts a framed byte stream from the host/ROM side over a valid/ready handshake.
- Writes one zero-extended weight word per data byte, in the layer/unit/input order the read driver consumes.
- Checks a trailing checksum; reports done or error to the network controller.

Parameters:
ADDR_W, 10, RAM address width
DATA_W, 32, RAM word width
BASE_ADDR, 0, address of layer 0 / unit 0 / input 0
SYNC_BYTE, 8'hA5, frame start marker
UNITS, 4, neural units per layer
INPUTS, 4, weights per unit
MAX_LAYERS, 4, maximum layer count accepted

Ports:
clk  input  1  system clock (post clock-wizard)
reset  input  1  asynchronous, active-high reset
load_start  input  1  one-cycle pulse; arms the loader
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts byte this cycle
ram_addr  output  ADDR_W  RAM write address
ram_we  output  1  RAM write enable
ram_din  output  DATA_W  RAM write data, {24'b0, weight}
busy  output  1  frame in progress
load_done  output  1  one-cycle pulse: frame complete, checksum good
load_err  output  1  sticky error flag; cleared by next load_start or reset
words_written  output  ADDR_W  weights written in the current/last frame

Behaviour:
- Async reset: state=IDLE; all outputs 0; counters and checksum 0.
- Byte transfer: occurs only when in_valid && in_ready on a rising clk edge.
- in_ready: 1 only in SYNC, COUNT, DATA and CHECK.
- FSM states: IDLE, SYNC, COUNT, DATA, CHECK, DONE, ERR.
- IDLE: load_start -> SYNC. Clears load_err, words_written, checksum, and the layer/unit/input counters.
- SYNC: bytes other than SYNC_BYTE are accepted and discarded. SYNC_BYTE -> COUNT.
- COUNT: accepted byte N is the layer count.
  - N in 1..MAX_LAYERS: latch N -> DATA.
  - Otherwise -> ERR.
- DATA: each accepted byte produces a registered write one cycle later (latency 1):
  - ram_we=1, ram_din={24'b0, byte}.
  - ram_addr = BASE_ADDR + layer*UNITS*INPUTS + unit*INPUTS + input.
  - checksum += byte (mod 256); words_written += 1.
  - Counter order: input increments fastest, wraps at INPUTS-1 into unit; unit wraps at UNITS-1 into layer.
  - After the write for layer N-1 / unit UNITS-1 / input INPUTS-1 -> CHECK.
  - Back-to-back accepted bytes give consecutive single-cycle writes, no bubbles.
- CHECK: accepted byte compared with checksum.
  - Equal -> DONE.
  - Unequal -> ERR. RAM contents are not rolled back.
- DONE: load_done=1 for exactly one cycle -> IDLE.
- ERR: load_err=1 (sticky) -> IDLE the next cycle.
- busy: 1 in every state except IDLE.
- load_start while busy: ignored.
- load_start in the cycle that DONE/ERR returns to IDLE: also ignored; the host re-pulses.
- in_valid dropping mid-frame: FSM holds state indefinitely; no timeout.
- Reset mid-frame: aborts immediately. Partial RAM writes remain; words_written reads 0.
- Width rule: address arithmetic in ADDR_W bits, wraps modulo 2^ADDR_W. The integrator keeps BASE_ADDR + MAX_LAYERS*UNITS*INPUTS <= 2^ADDR_W.

Decomposition:
- Shared package (network_pkg):
  - FSM state typedef.
  - SYNC_BYTE, UNITS, INPUTS, MAX_LAYERS constants.
  - Address-mapping function (layer, unit, input -> offset), also used by the read driver so both agree.
- One natural sub-module: weight_addr_counter. Holds the nested input/unit/layer counters, the last-weight flag and the address output.

Test Plan:
- Reset, then load_start, stream A5,01, bytes 00..0F, check 78 -> 16 writes to addr 0..15 with din=00..0F, load_done pulse, load_err=0, words_written=16.
- Noise bytes 11,22 then A5,02, 32 bytes of 01, check 20 -> noise discarded, writes to addr 0..31, load_done.
- A5,05 -> load_err=1, no ram_we asserted, FSM back in IDLE; a later load_start clears load_err.
- A5,01, bytes 00..0F, check 00 -> 16 writes occur, load_err=1, no load_done.
- in_valid toggled randomly during DATA -> writes only on accepted bytes, addresses stay contiguous, final RAM image identical to the back-to-back run.
- Reset asserted after 7 data bytes -> all outputs 0 asynchronously; a fresh load_start plus full frame then succeeds.
